// File: rtl/tpu_mem_pkg.sv
// Shared constants and FSM state type for the TPU memory controllers.
package tpu_mem_pkg;

  localparam int unsigned ARRAY_SIZE = 16;
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WRITE,
    DONE
  } mem_ctrl_state_t;

  // Number of skewed write steps: rows + banks - 1, from the "last index" encodings.
  function automatic logic [CNT_WIDTH:0] num_steps(input logic [CNT_WIDTH-1:0] num_row,
                                                   input logic [CNT_WIDTH-1:0] num_col);
    return {1'b0, num_row} + {1'b0, num_col} + (CNT_WIDTH + 1)'(1);
  endfunction

endpackage

// File: rtl/result_mem_write_control_if.sv
// Command/response bundle between the sequencer and the result write controller.
interface result_mem_write_control_if
  import tpu_mem_pkg::*;
;

  logic                             active;
  logic [ADDR_WIDTH-1:0]            base_addr;
  logic [CNT_WIDTH-1:0]             num_row;
  logic [CNT_WIDTH-1:0]             num_col;
  logic [ARRAY_SIZE*ADDR_WIDTH-1:0] out_addr;
  logic [ARRAY_SIZE-1:0]            out_wr_en;
  logic                             busy;
  logic                             done;

  modport master (
    output active, base_addr, num_row, num_col,
    input  out_addr, out_wr_en, busy, done
  );

  modport slave (
    input  active, base_addr, num_row, num_col,
    output out_addr, out_wr_en, busy, done
  );

endinterface

// File: rtl/write_skew_lane.sv
// One bank lane of the skewed write pattern: lane LANE writes row (t - LANE) when in range.
module write_skew_lane
  import tpu_mem_pkg::*;
#(
  parameter int unsigned LANE = 0
) (
  input  logic [CNT_WIDTH:0]    t,
  input  logic [CNT_WIDTH-1:0]  num_row,
  input  logic [CNT_WIDTH-1:0]  num_col,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  en,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [CNT_WIDTH:0] LaneIdx = (CNT_WIDTH + 1)'(LANE);

  logic [CNT_WIDTH+1:0] t_diff;
  logic [CNT_WIDTH+1:0] col_diff;
  logic [CNT_WIDTH:0]   row_off;

  // Range checks via borrow bits so lane 0 needs no always-true compare.
  always_comb begin
    t_diff   = {1'b0, t} - {1'b0, LaneIdx};
    col_diff = {2'b00, num_col} - {1'b0, LaneIdx};
    row_off  = t_diff[CNT_WIDTH:0];
    en       = !t_diff[CNT_WIDTH+1] && !col_diff[CNT_WIDTH+1] &&
               (row_off <= {1'b0, num_row});
    // Offset only reaches the address when the lane is enabled, so no underflow leaks out.
    addr     = en ? (base_addr + ADDR_WIDTH'(row_off)) : '0;
  end

endmodule

// File: rtl/result_mem_write_control.sv
// Turns the drained, diagonally skewed result stream into per-bank write enables/addresses.
module result_mem_write_control
  import tpu_mem_pkg::*;
#(
  parameter int unsigned DRAIN_LAT = 2
) (
  input logic                       clk,
  input logic                       reset,
  result_mem_write_control_if.slave bus
);

  localparam int unsigned DrainW = (DRAIN_LAT > 0) ? $clog2(DRAIN_LAT + 1) : 1;

  mem_ctrl_state_t                  state_q;
  logic [DrainW-1:0]                drain_q;
  logic [CNT_WIDTH:0]               t_q;
  logic [ADDR_WIDTH-1:0]            base_q;
  logic [CNT_WIDTH-1:0]             num_row_q;
  logic [CNT_WIDTH-1:0]             num_col_q;
  logic [ARRAY_SIZE*ADDR_WIDTH-1:0] out_addr_q;
  logic [ARRAY_SIZE-1:0]            out_wr_en_q;
  logic                             busy_q;
  logic                             done_q;

  logic [ARRAY_SIZE-1:0]            lane_en;
  logic [ARRAY_SIZE*ADDR_WIDTH-1:0] lane_addr;

  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_lane
    write_skew_lane #(
      .LANE (j)
    ) u_lane (
      .t         (t_q),
      .num_row   (num_row_q),
      .num_col   (num_col_q),
      .base_addr (base_q),
      .en        (lane_en[j]),
      .addr      (lane_addr[j*ADDR_WIDTH +: ADDR_WIDTH])
    );
  end

  // Sequencing FSM; lane outputs are registered one cycle behind the step counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      drain_q     <= '0;
      t_q         <= '0;
      base_q      <= '0;
      num_row_q   <= '0;
      num_col_q   <= '0;
      out_addr_q  <= '0;
      out_wr_en_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          out_addr_q  <= '0;
          out_wr_en_q <= '0;
          done_q      <= 1'b0;
          t_q         <= '0;
          if (bus.active) begin
            base_q    <= bus.base_addr;
            num_row_q <= bus.num_row;
            num_col_q <= bus.num_col;
            busy_q    <= 1'b1;
            drain_q   <= DrainW'(DRAIN_LAT);
            state_q   <= (DRAIN_LAT == 0) ? WRITE : WAIT;
          end
        end
        WAIT: begin
          drain_q <= drain_q - DrainW'(1);
          if (drain_q == DrainW'(1)) begin
            state_q <= WRITE;
          end
        end
        WRITE: begin
          out_addr_q  <= lane_addr;
          out_wr_en_q <= lane_en;
          // t == S is a flush step: no lane is in range, so outputs clear as done rises.
          if (t_q == num_steps(num_row_q, num_col_q)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            t_q     <= '0;
            state_q <= DONE;
          end else begin
            t_q <= t_q + (CNT_WIDTH + 1)'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_addr  = out_addr_q;
  assign bus.out_wr_en = out_wr_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_result_mem_write_control.sv
// Directed bench for result_mem_write_control (DRAIN_LAT=2 and DRAIN_LAT=0 instances).
module tb_result_mem_write_control;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  result_mem_write_control_if bus_a ();
  result_mem_write_control_if bus_b ();

  result_mem_write_control #(
    .DRAIN_LAT (2)
  ) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  result_mem_write_control #(
    .DRAIN_LAT (0)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] nom_en [0:10];

  initial begin
    checks = 0;
    errors = 0;
    nom_en[0]  = 16'h0001; nom_en[1] = 16'h0003; nom_en[2] = 16'h0007;
    nom_en[3]  = 16'h000F; nom_en[4] = 16'h001E; nom_en[5] = 16'h003C;
    nom_en[6]  = 16'h0078; nom_en[7] = 16'h00F0; nom_en[8] = 16'h00E0;
    nom_en[9]  = 16'h00C0; nom_en[10] = 16'h0080;

    bus_a.active = 1'b0; bus_a.base_addr = '0; bus_a.num_row = '0; bus_a.num_col = '0;
    bus_b.active = 1'b0; bus_b.base_addr = '0; bus_b.num_row = '0; bus_b.num_col = '0;
    reset = 1'b1;
    #1;
    check("rst_a_wr_en", bus_a.out_wr_en, 0);
    check("rst_a_addr", bus_a.out_addr, 0);
    check("rst_a_busy", bus_a.busy, 0);
    check("rst_a_done", bus_a.done, 0);
    check("rst_b_busy", bus_b.busy, 0);
    tick(2);
    reset = 1'b0;
    tick(1);

    // 1. Nominal run; inputs are scrambled after acceptance to show they were captured.
    bus_a.base_addr = 8'h00; bus_a.num_row = 4'd3; bus_a.num_col = 4'd7; bus_a.active = 1'b1;
    tick(1);
    bus_a.active = 1'b0;
    bus_a.base_addr = 8'h77; bus_a.num_row = 4'd0; bus_a.num_col = 4'd0;
    check("nom_busy_n", bus_a.busy, 1);
    check("nom_wr_en_n", bus_a.out_wr_en, 0);
    tick(1);
    check("nom_wait1_wr_en", bus_a.out_wr_en, 0);
    tick(1);
    check("nom_wait2_wr_en", bus_a.out_wr_en, 0);
    check("nom_wait2_busy", bus_a.busy, 1);
    for (int t = 0; t <= 10; t++) begin
      tick(1);
      check($sformatf("nom_wr_en_t%0d", t), bus_a.out_wr_en, nom_en[t]);
      if (t == 0) check("nom_addr_t0", bus_a.out_addr, 128'h0);
      if (t == 3) check("nom_addr_t3", bus_a.out_addr, 128'h0001_0203);
      if (t == 10) check("nom_addr_t10", bus_a.out_addr, 128'h03 << 56);
      check($sformatf("nom_done_t%0d", t), bus_a.done, 0);
    end
    tick(1);
    check("nom_done", bus_a.done, 1);
    check("nom_done_busy", bus_a.busy, 0);
    check("nom_done_wr_en", bus_a.out_wr_en, 0);
    check("nom_done_addr", bus_a.out_addr, 0);
    tick(1);
    check("nom_done_pulse", bus_a.done, 0);

    // 2. Address wrap on a single lane.
    bus_a.base_addr = 8'hFE; bus_a.num_row = 4'd3; bus_a.num_col = 4'd0; bus_a.active = 1'b1;
    tick(1);
    bus_a.active = 1'b0;
    tick(3);
    check("wrap_en0", bus_a.out_wr_en, 16'h0001);
    check("wrap_addr0", bus_a.out_addr, 128'hFE);
    tick(1);
    check("wrap_en1", bus_a.out_wr_en, 16'h0001);
    check("wrap_addr1", bus_a.out_addr, 128'hFF);
    tick(1);
    check("wrap_en2", bus_a.out_wr_en, 16'h0001);
    check("wrap_addr2", bus_a.out_addr, 128'h00);
    tick(1);
    check("wrap_en3", bus_a.out_wr_en, 16'h0001);
    check("wrap_addr3", bus_a.out_addr, 128'h01);
    tick(1);
    check("wrap_done", bus_a.done, 1);
    check("wrap_done_en", bus_a.out_wr_en, 0);
    tick(1);

    // 3. Full array with no drain latency.
    bus_b.base_addr = 8'h10; bus_b.num_row = 4'd15; bus_b.num_col = 4'd15; bus_b.active = 1'b1;
    tick(1);
    bus_b.active = 1'b0;
    check("full_busy_n", bus_b.busy, 1);
    check("full_wr_en_n", bus_b.out_wr_en, 0);
    for (int t = 0; t <= 30; t++) begin
      tick(1);
      if (t == 0) check("full_en_t0", bus_b.out_wr_en, 16'h0001);
      if (t == 0) check("full_addr_t0", bus_b.out_addr, 128'h10);
      if (t == 15) check("full_en_t15", bus_b.out_wr_en, 16'hFFFF);
      if (t == 15) check("full_addr_t15", bus_b.out_addr,
                         128'h1011_1213_1415_1617_1819_1A1B_1C1D_1E1F);
      if (t == 30) check("full_en_t30", bus_b.out_wr_en, 16'h8000);
      if (t == 30) check("full_addr_t30", bus_b.out_addr, 128'h1F << 120);
      if (t == 30) check("full_busy_t30", bus_b.busy, 1);
    end
    tick(1);
    check("full_done", bus_b.done, 1);
    check("full_done_busy", bus_b.busy, 0);
    check("full_other_idle", bus_a.busy, 0);
    tick(1);
    check("full_done_pulse", bus_b.done, 0);

    // 4. Restart attempts during WRITE and DONE are ignored.
    bus_a.base_addr = 8'h20; bus_a.num_row = 4'd1; bus_a.num_col = 4'd1; bus_a.active = 1'b1;
    tick(1);
    bus_a.active = 1'b0;
    tick(3);
    check("ign_en_t0", bus_a.out_wr_en, 16'h0001);
    check("ign_addr_t0", bus_a.out_addr, 128'h20);
    bus_a.base_addr = 8'h80; bus_a.num_row = 4'd5; bus_a.num_col = 4'd5; bus_a.active = 1'b1;
    tick(1);
    bus_a.active = 1'b0;
    check("ign_en_t1", bus_a.out_wr_en, 16'h0003);
    check("ign_addr_t1", bus_a.out_addr, 128'h2021);
    tick(1);
    check("ign_en_t2", bus_a.out_wr_en, 16'h0002);
    check("ign_addr_t2", bus_a.out_addr, 128'h2100);
    tick(1);
    check("ign_done", bus_a.done, 1);
    bus_a.base_addr = 8'h40; bus_a.num_row = 4'd0; bus_a.num_col = 4'd0; bus_a.active = 1'b1;
    tick(1);
    check("ign_active_in_done_busy", bus_a.busy, 0);
    check("ign_active_in_done_done", bus_a.done, 0);
    tick(1);
    bus_a.active = 1'b0;
    check("restart_busy", bus_a.busy, 1);
    tick(2);
    check("restart_wait_en", bus_a.out_wr_en, 0);
    tick(1);
    check("restart_en", bus_a.out_wr_en, 16'h0001);
    check("restart_addr", bus_a.out_addr, 128'h40);
    tick(1);
    check("restart_done", bus_a.done, 1);
    tick(1);

    // 5. Asynchronous reset in the middle of a nominal run.
    bus_a.base_addr = 8'h00; bus_a.num_row = 4'd3; bus_a.num_col = 4'd7; bus_a.active = 1'b1;
    tick(1);
    bus_a.active = 1'b0;
    tick(7);
    check("abort_en_t4", bus_a.out_wr_en, 16'h001E);
    check("abort_addr_t4", bus_a.out_addr, 128'h00_0102_0300);
    #2;
    reset = 1'b1;
    #1;
    check("abort_async_en", bus_a.out_wr_en, 0);
    check("abort_async_addr", bus_a.out_addr, 0);
    check("abort_async_busy", bus_a.busy, 0);
    tick(1);
    check("abort_no_done0", bus_a.done, 0);
    reset = 1'b0;
    tick(1);
    check("abort_no_done1", bus_a.done, 0);
    check("abort_idle_en", bus_a.out_wr_en, 0);
    bus_a.active = 1'b1;
    tick(1);
    bus_a.active = 1'b0;
    check("rerun_busy", bus_a.busy, 1);
    tick(3);
    check("rerun_en_t0", bus_a.out_wr_en, 16'h0001);
    tick(3);
    check("rerun_en_t3", bus_a.out_wr_en, 16'h000F);
    check("rerun_addr_t3", bus_a.out_addr, 128'h0001_0203);
    tick(7);
    check("rerun_en_t10", bus_a.out_wr_en, 16'h0080);
    tick(1);
    check("rerun_done", bus_a.done, 1);
    tick(1);

    // 6. Minimum size: one write, done four cycles after acceptance.
    bus_a.base_addr = 8'h55; bus_a.num_row = 4'd0; bus_a.num_col = 4'd0; bus_a.active = 1'b1;
    tick(1);
    bus_a.active = 1'b0;
    check("min_busy", bus_a.busy, 1);
    tick(2);
    check("min_wait_en", bus_a.out_wr_en, 0);
    tick(1);
    check("min_en", bus_a.out_wr_en, 16'h0001);
    check("min_addr", bus_a.out_addr, 128'h55);
    check("min_not_done", bus_a.done, 0);
    tick(1);
    check("min_done", bus_a.done, 1);
    check("min_done_busy", bus_a.busy, 0);
    check("min_done_en", bus_a.out_wr_en, 0);
    tick(1);
    check("min_done_pulse", bus_a.done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
